mem_access_unit: RTL

// - Parametrised MEM-stage load/store unit between exe_mem and mem_wb; drives a handshaked multi-cycle RAM port.
// - Stores use byte enables; there is no read-modify-write. Loads are lane-extracted and sign/zero-extended.
// - Stalls the pipeline until the RAM acknowledges. Flags bus timeouts and misaligned accesses.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// RAM-side handshake bundle of the MEM-stage load/store unit.
// master = load/store unit, slave = RAM controller.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      ram_req_o;
    logic                      ram_we_o;
    logic [DATA_WIDTH/8-1:0]   ram_be_o;
    logic [ADDR_WIDTH-1:0]     ram_addr_o;
    logic [DATA_WIDTH-1:0]     ram_wdata_o;
    logic [DATA_WIDTH-1:0]     ram_rdata_i;
    logic                      ram_ack_i;

    modport master (
        output ram_req_o,
        output ram_we_o,
        output ram_be_o,
        output ram_addr_o,
        output ram_wdata_o,
        input  ram_rdata_i,
        input  ram_ack_i
    );

    modport slave (
        input  ram_req_o,
        input  ram_we_o,
        input  ram_be_o,
        input  ram_addr_o,
        input  ram_wdata_o,
        output ram_rdata_i,
        output ram_ack_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with a handshaked multi-cycle RAM port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module mem_access_unit #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] HALT_ADDR   = 32'h0000_1000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [31:0]           reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic [3:0]            mem_op_i,
    mem_access_unit_if.master     ram,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [31:0]           reg_wdata_o,
    output logic                  stall_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  halt_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [3:0] OP_LB   = 4'b0000;
    localparam logic [3:0] OP_LH   = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_LBU  = 4'b0100;
    localparam logic [3:0] OP_LHU  = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b1000;
    localparam logic [3:0] OP_SH   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE,
        ERR
    } state_e;

    state_e                  state_q, state_d;
    logic                    mem_i, st_i, sx_i, trap_i;
    logic [1:0]              sz_i;
    logic [OFFW-1:0]         off_i, off_use;
    logic [1:0]              sz_q;
    logic                    st_q, sx_q, we_q, mis_q;
    logic [OFFW-1:0]         off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             data_q;
    logic [4:0]              waddr_q;
    logic [7:0]              timer_q, timer_d;
    logic [31:0]             load_d, load_q, v;
    logic                    halt_q, halt_set;
    logic [NB-1:0]           be_base;

    always_comb begin
        mem_i = 1'b1;
        sz_i  = 2'd0;
        st_i  = 1'b0;
        sx_i  = 1'b0;
        unique case (1'b1)
            (mem_op_i == OP_LB):  begin sz_i = 2'd0; sx_i = 1'b1; end
            (mem_op_i == OP_LH):  begin sz_i = 2'd1; sx_i = 1'b1; end
            (mem_op_i == OP_LW):  sz_i = 2'd2;
            (mem_op_i == OP_LBU): sz_i = 2'd0;
            (mem_op_i == OP_LHU): sz_i = 2'd1;
            (mem_op_i == OP_SB):  begin sz_i = 2'd0; st_i = 1'b1; end
            (mem_op_i == OP_SH):  begin sz_i = 2'd1; st_i = 1'b1; end
            (mem_op_i == OP_SW):  begin sz_i = 2'd2; st_i = 1'b1; end
            default:              mem_i = 1'b0;
        endcase
    end

    assign off_i = mem_addr_i[OFFW-1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    logic mis_i;
    assign mis_i   = ((sz_i == 2'd1) && off_i[0]) ||
                     ((sz_i == 2'd2) && (off_i[1:0] != 2'b00));
    assign trap_i  = mis_i;
    assign off_use = off_i;
`else
    localparam bit TRAP_EN = 1'b0;
    logic [OFFW-1:0] amask;
    // Misaligned H/W accesses silently round down to their natural boundary.
    assign amask   = (sz_i == 2'd2) ? OFFW'(3) :
                     (sz_i == 2'd1) ? OFFW'(1) : '0;
    assign trap_i  = 1'b0;
    assign off_use = off_i & ~amask;
`endif

    always_comb begin
        v = 32'(ram.ram_rdata_i >> {off_q, 3'b000});
        unique case (sz_q)
            2'd0:    load_d = sx_q ? {{24{v[7]}}, v[7:0]}
                                   : {24'h0, v[7:0]};
            2'd1:    load_d = sx_q ? {{16{v[15]}}, v[15:0]}
                                   : {16'h0, v[15:0]};
            default: load_d = v;
        endcase
    end

    always_comb begin
        unique case (sz_q)
            2'd0:    be_base = NB'(4'h1);
            2'd1:    be_base = NB'(4'h3);
            default: be_base = NB'(4'hF);
        endcase
    end

    assign halt_set = (state_q == DONE) && st_q && (sz_q == 2'd2) &&
                      (addr_q == ADDR_WIDTH'(HALT_ADDR));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            sz_q    <= '0;
            st_q    <= 1'b0;
            sx_q    <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            waddr_q <= '0;
            load_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_q == IDLE && mem_i) begin
                sz_q    <= sz_i;
                st_q    <= st_i;
                sx_q    <= sx_i;
                we_q    <= reg_we_i;
                mis_q   <= trap_i;
                off_q   <= off_use;
                addr_q  <= mem_addr_i;
                data_q  <= mem_data_i;
                waddr_q <= reg_waddr_i;
            end
            if (state_q == BUS && ram.ram_ack_i) begin
                load_q <= load_d;
            end
            if (halt_set) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        stall_o         = 1'b0;
        reg_waddr_o     = '0;
        reg_we_o        = 1'b0;
        reg_wdata_o     = '0;
        misalign_o      = 1'b0;
        bus_err_o       = 1'b0;
        ram.ram_req_o   = 1'b0;
        ram.ram_we_o    = 1'b0;
        ram.ram_be_o    = '0;
        ram.ram_addr_o  = '0;
        ram.ram_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (mem_i) begin
                    stall_o = 1'b1;
                    state_d = trap_i ? ERR : BUS;
                end else begin
                    reg_waddr_o = reg_waddr_i;
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = reg_wdata_i;
                end
            end
            BUS: begin
                stall_o         = 1'b1;
                ram.ram_req_o   = 1'b1;
                ram.ram_we_o    = st_q;
                ram.ram_be_o    = st_q ? (be_base << off_q) : '1;
                ram.ram_addr_o  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                ram.ram_wdata_o = DATA_WIDTH'(data_q) << {off_q, 3'b000};
                // Ack beats the timeout when both land in the same cycle.
                if (ram.ram_ack_i) begin
                    state_d = DONE;
                    timer_d = '0;
                end else if (timer_q == 8'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DONE: begin
                reg_waddr_o = waddr_q;
                reg_we_o    = we_q & ~st_q;
                reg_wdata_o = st_q ? '0 : load_q;
                state_d     = IDLE;
            end
            default: begin
                misalign_o = TRAP_EN & mis_q;
                bus_err_o  = ~mis_q;
                state_d    = IDLE;
            end
        endcase
        // Outputs read zero for the whole reset, including the comb paths.
        if (!rst_ni) begin
            stall_o         = 1'b0;
            reg_waddr_o     = '0;
            reg_we_o        = 1'b0;
            reg_wdata_o     = '0;
            misalign_o      = 1'b0;
            bus_err_o       = 1'b0;
            ram.ram_req_o   = 1'b0;
            ram.ram_we_o    = 1'b0;
            ram.ram_be_o    = '0;
            ram.ram_addr_o  = '0;
            ram.ram_wdata_o = '0;
        end
    end

    assign halt_o = rst_ni & (halt_q | halt_set);

endmodule
